// File: rtl/sr_cmd_driver.sv
// Command stage for an SR flip-flop: synchronises and debounces raw set/clear requests and
// turns each debounced rising edge into a timed, mutually exclusive S or R pulse.
module sr_cmd_driver #(
    parameter int unsigned DB_CYCLES    = 4,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic q_model
);

    localparam int unsigned DbW  = $clog2(DB_CYCLES + 1);
    localparam int unsigned TMax = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMax + 1);

    localparam logic [DbW-1:0] DbLast    = DbW'(DB_CYCLES - 1);
    localparam logic [TW-1:0]  PulseLast = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0]  GapLast   = TW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

    // Channel index 0 is set, 1 is clear.
    logic [1:0]           sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]           db_q, db_d, db_dly_q, db_dly_d;
    logic [1:0][DbW-1:0]  cnt_q, cnt_d;

    state_e               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 cmd_q, cmd_d;
    logic                 s_q, s_d, r_q, r_d;
    logic                 busy_q, busy_d;
    logic                 conflict_q, conflict_d;
    logic                 q_model_q, q_model_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 pend_cmd_q, pend_cmd_d;

    logic                 set_ev, clr_ev, one_ev, direct;
    logic                 start, start_cmd, take_pend;

    always_comb begin
        sync1_d  = {clr_in, set_in};
        sync2_d  = sync1_q;
        db_dly_d = db_q;
        db_d     = db_q;
        cnt_d    = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign set_ev = db_q[0] & ~db_dly_q[0];
    assign clr_ev = db_q[1] & ~db_dly_q[1];

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        cmd_d        = cmd_q;
        s_d          = s_q;
        r_d          = r_q;
        q_model_d    = q_model_q;
        pend_valid_d = pend_valid_q;
        pend_cmd_d   = pend_cmd_q;
        take_pend    = 1'b0;
        start        = 1'b0;
        start_cmd    = pend_cmd_q;
        one_ev       = set_ev ^ clr_ev;
        direct       = one_ev && (state_q == StIdle) && !pend_valid_q;

        case (state_q)
            StIdle: begin
                if (pend_valid_q) begin
                    start     = 1'b1;
                    take_pend = 1'b1;
                end else if (one_ev) begin
                    start     = 1'b1;
                    start_cmd = set_ev;
                end
            end
            StDrive: begin
                if (tmr_q == PulseLast) begin
                    s_d       = 1'b0;
                    r_d       = 1'b0;
                    q_model_d = cmd_q;
                    tmr_d     = '0;
                    if (GAP_CYCLES != 0) begin
                        state_d = StGap;
                    end else if (pend_valid_q) begin
                        start     = 1'b1;
                        take_pend = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StGap: begin
                if (tmr_q == GapLast) begin
                    tmr_d = '0;
                    if (pend_valid_q) begin
                        start     = 1'b1;
                        take_pend = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            state_d = StDrive;
            tmr_d   = '0;
            cmd_d   = start_cmd;
            s_d     = start_cmd;
            r_d     = ~start_cmd;
        end

        // A new event lands after the consume so it survives in the slot (latest wins).
        if (take_pend) pend_valid_d = 1'b0;
        if (one_ev && !direct) begin
            pend_valid_d = 1'b1;
            pend_cmd_d   = set_ev;
        end

        conflict_d = set_ev & clr_ev;
        busy_d     = (state_d != StIdle) || pend_valid_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            db_dly_q     <= '0;
            cnt_q        <= '0;
            state_q      <= StIdle;
            tmr_q        <= '0;
            cmd_q        <= 1'b0;
            s_q          <= 1'b0;
            r_q          <= 1'b0;
            busy_q       <= 1'b0;
            conflict_q   <= 1'b0;
            q_model_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_cmd_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            db_dly_q     <= db_dly_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            cmd_q        <= cmd_d;
            s_q          <= s_d;
            r_q          <= r_d;
            busy_q       <= busy_d;
            conflict_q   <= conflict_d;
            q_model_q    <= q_model_d;
            pend_valid_q <= pend_valid_d;
            pend_cmd_q   <= pend_cmd_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
    assign q_model  = q_model_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver: a per-cycle vector table for reset/set/clear plus
// hand-written sequences for bounce, conflict, overwrite and mid-pulse reset.
module tb_sr_cmd_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic set_in = 1'b0;
    logic clr_in = 1'b0;

    logic d_s, d_r, d_busy, d_conf, d_q;
    logic b_s, b_r, b_busy, b_conf, b_q;
    logic p_s, p_r, p_busy, p_conf, p_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sr_cmd_driver #(.DB_CYCLES(4), .PULSE_CYCLES(1), .GAP_CYCLES(1)) u_def (
        .clk(clk), .reset(reset), .set_in(set_in), .clr_in(clr_in),
        .s(d_s), .r(d_r), .busy(d_busy), .conflict(d_conf), .q_model(d_q)
    );

    sr_cmd_driver #(.DB_CYCLES(1), .PULSE_CYCLES(2), .GAP_CYCLES(1)) u_b2b (
        .clk(clk), .reset(reset), .set_in(set_in), .clr_in(clr_in),
        .s(b_s), .r(b_r), .busy(b_busy), .conflict(b_conf), .q_model(b_q)
    );

    sr_cmd_driver #(.DB_CYCLES(4), .PULSE_CYCLES(4), .GAP_CYCLES(1)) u_p4 (
        .clk(clk), .reset(reset), .set_in(set_in), .clr_in(clr_in),
        .s(p_s), .r(p_r), .busy(p_busy), .conflict(p_conf), .q_model(p_q)
    );

    // Expected bits: {s, r, busy, conflict, q_model}
    typedef struct {
        logic       set_i;
        logic       clr_i;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input int step, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in = 1'b0;
        clr_in = 1'b0;
        reset  = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    initial begin
        int conf_cnt;
        logic bset;

        for (int i = 0; i < 20; i++) begin
            vecs[i].set_i = 1'b1;
            vecs[i].clr_i = (i >= 9);
            vecs[i].exp   = (i >= 7 && i <= 15) ? 5'b00001 : 5'b00000;
        end
        vecs[6].exp  = 5'b10100;
        vecs[7].exp  = 5'b00101;
        vecs[15].exp = 5'b01101;
        vecs[16].exp = 5'b00100;

        // Reset held with set_in high: outputs cleared without any clock edge.
        set_in = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("async_reset", 0, {3'b0, d_s, d_r, d_busy, d_conf, d_q}, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("reset_hold", i, {3'b0, d_s, d_r, d_busy, d_conf, d_q}, 8'h00);
        end
        reset = 1'b1;

        // Release, then set and later clear.
        for (int i = 0; i < 20; i++) begin
            set_in = vecs[i].set_i;
            clr_in = vecs[i].clr_i;
            tick();
            check("set_clr_vec", i + 1, {3'b0, d_s, d_r, d_busy, d_conf, d_q},
                  {3'b0, vecs[i].exp});
        end

        // Bounce: 1,1,0,1,1,0 then steady high from step 7; one pulse at step 13.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            set_in = !(i == 3 || i == 6);
            tick();
            check("bounce", i, {6'b0, d_s, d_r}, {6'b0, (i == 13), 1'b0});
        end

        // Simultaneous rise on both lines.
        do_reset();
        conf_cnt = 0;
        for (int i = 1; i <= 15; i++) begin
            set_in = 1'b1;
            clr_in = 1'b1;
            tick();
            if (d_conf) conf_cnt++;
            check("conflict_quiet", i, {4'b0, d_s, d_r, d_busy, d_q}, 8'h00);
        end
        check("conflict_count", 15, 8'(conf_cnt), 8'd1);

        // Overwrite (DB=1, PULSE=2, GAP=1): set, then clr, then set while busy.
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            set_in = (i != 2);
            clr_in = (i >= 2);
            tick();
            bset = (i == 4 || i == 5 || i == 7 || i == 8);
            check("overwrite", i, {4'b0, b_s, b_r, b_busy, b_q},
                  {4'b0, bset, 1'b0, (i >= 4 && i <= 9), (i >= 6)});
        end

        // Reset during the second DRIVE cycle of a 4-cycle pulse.
        do_reset();
        set_in = 1'b1;
        repeat (6) tick();
        tick();
        check("p4_drive1", 7, {7'b0, p_s}, 8'h01);
        tick();
        check("p4_drive2", 8, {7'b0, p_s}, 8'h01);
        reset  = 1'b0;
        set_in = 1'b0;
        #1;
        check("p4_async_drop", 8, {4'b0, p_s, p_r, p_busy, p_q}, 8'h00);
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("p4_after", i, {4'b0, p_s, p_r, p_busy, p_q}, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
